ram_dp_clear: RTL and testbench

RAM_DP_CLEAR -- requirements
Module: ram_dp_clear

---
 rtl/ram_dp_clear.sv | 186 ++++++++++++++++++
 tb/tb_ram_dp_clear.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clear.sv
// Simple dual-port RAM with byte-lane writes, 1- or 2-cycle registered reads and a
// clear engine that sweeps CLEAR_VALUE through every word after reset or on request.
module ram_dp_clear #(
  parameter int                    DATA_WIDTH    = 16,
  parameter int                    ADDRESS_WIDTH = 8,
  parameter int                    DEPTH         = 1 << ADDRESS_WIDTH,
  parameter int                    BYTE_WIDTH    = 8,
  parameter int                    READ_LATENCY  = 1,
  parameter int                    RDW_MODE      = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDRESS_WIDTH-1:0]         write_address,
  input  logic                             Write_Enable,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] Byte_Enable,
  input  logic [DATA_WIDTH-1:0]            DATA_WRITE,
  input  logic [ADDRESS_WIDTH-1:0]         read_address,
  input  logic                             Read_Enable,
  output logic [DATA_WIDTH-1:0]            DATA_READ,
  output logic                             Read_Valid,
  input  logic                             Clear_Request,
  output logic                             Busy
);

  localparam int                     LANES     = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W   = (ADDRESS_WIDTH + 1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                   state_r, state_s;
  logic [ADDRESS_WIDTH-1:0] clr_addr_r, clr_addr_s;
  logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
  logic                     busy_s, wr_accept_s, rd_accept_s;
  logic                     wr_in_range_s, rd_in_range_s;
  logic [DATA_WIDTH-1:0]    old_word_s, rd_word_s;
  logic [DATA_WIDTH-1:0]    rd_data_r;
  logic                     rd_valid_r;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      lane_en
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (lane_en[i]) begin
        result[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else begin
        result[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    return result;
  endfunction

  assign wr_in_range_s = ({1'b0, write_address} < DEPTH_W);
  assign rd_in_range_s = ({1'b0, read_address} < DEPTH_W);

  // State register and clear address counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= CLEAR;
      clr_addr_r <= '0;
    end else begin
      state_r    <= state_s;
      clr_addr_r <= clr_addr_s;
    end
  end

  // Next-state: sweep to the last word, then wait for a clear request
  always_comb begin
    state_s    = state_r;
    clr_addr_s = clr_addr_r;
    case (state_r)
      CLEAR: begin
        if (clr_addr_r == LAST_ADDR) begin
          state_s    = READY;
          clr_addr_s = '0;
        end else begin
          state_s    = CLEAR;
          clr_addr_s = clr_addr_r + ADDRESS_WIDTH'(1);
        end
      end
      READY: begin
        if (Clear_Request) begin
          state_s    = CLEAR;
          clr_addr_s = '0;
        end else begin
          state_s    = READY;
          clr_addr_s = clr_addr_r;
        end
      end
      default: begin
        state_s    = CLEAR;
        clr_addr_s = '0;
      end
    endcase
  end

  // Output decode: user traffic is only accepted while READY
  always_comb begin
    busy_s      = 1'b0;
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    case (state_r)
      CLEAR: busy_s = 1'b1;
      READY: begin
        wr_accept_s = Write_Enable & wr_in_range_s & ~reset;
        rd_accept_s = Read_Enable & ~reset;
      end
      default: busy_s = 1'b1;
    endcase
  end

  // Read word selection, including the same-address write bypass
  always_comb begin
    old_word_s = CLEAR_VALUE;
    rd_word_s  = CLEAR_VALUE;
    if (rd_in_range_s) begin
      old_word_s = mem_r[read_address];
    end else begin
      old_word_s = CLEAR_VALUE;
    end
    if ((RDW_MODE == 1) && wr_accept_s && (write_address == read_address)) begin
      rd_word_s = merge_lanes(old_word_s, DATA_WRITE, Byte_Enable);
    end else begin
      rd_word_s = old_word_s;
    end
  end

  // Storage: the clear engine owns the write port while busy
  always_ff @(posedge clock) begin
    if (busy_s) begin
      mem_r[clr_addr_r] <= CLEAR_VALUE;
    end else if (wr_accept_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (Byte_Enable[i]) begin
          mem_r[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= DATA_WRITE[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_data_r;
      logic                  pipe_valid_r;

      // Two-stage read pipeline; in-flight reads drain even once a clear starts
      always_ff @(posedge clock) begin
        if (reset) begin
          pipe_valid_r <= 1'b0;
          pipe_data_r  <= '0;
          rd_valid_r   <= 1'b0;
          rd_data_r    <= '0;
        end else begin
          pipe_valid_r <= rd_accept_s;
          if (rd_accept_s) pipe_data_r <= rd_word_s;
          rd_valid_r <= pipe_valid_r;
          if (pipe_valid_r) rd_data_r <= pipe_data_r;
        end
      end
    end else begin : g_lat1
      // Single-stage read register; data holds between completions
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_valid_r <= 1'b0;
          rd_data_r  <= '0;
        end else begin
          rd_valid_r <= rd_accept_s;
          if (rd_accept_s) rd_data_r <= rd_word_s;
        end
      end
    end
  endgenerate

  assign DATA_READ  = rd_data_r;
  assign Read_Valid = rd_valid_r;
  assign Busy       = busy_s;

endmodule

// File: tb/tb_ram_dp_clear.sv
// Bench for ram_dp_clear: three instances (default, latency-2/new-data, short depth with a
// non-zero clear word) share one stimulus stream and are checked against a cycle-level model.
module tb_ram_dp_clear;

  logic        clock;
  logic        reset;
  logic [7:0]  write_address;
  logic        Write_Enable;
  logic [1:0]  Byte_Enable;
  logic [15:0] DATA_WRITE;
  logic [7:0]  read_address;
  logic        Read_Enable;
  logic        Clear_Request;
  logic [2:0]  busy_o;
  logic [2:0]  valid_o;
  logic [15:0] data_o [3];

  int checks;
  int errors;

  ram_dp_clear dut0 (
    .clock(clock), .reset(reset), .write_address(write_address), .Write_Enable(Write_Enable),
    .Byte_Enable(Byte_Enable), .DATA_WRITE(DATA_WRITE), .read_address(read_address),
    .Read_Enable(Read_Enable), .DATA_READ(data_o[0]), .Read_Valid(valid_o[0]),
    .Clear_Request(Clear_Request), .Busy(busy_o[0])
  );

  ram_dp_clear #(.READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .write_address(write_address), .Write_Enable(Write_Enable),
    .Byte_Enable(Byte_Enable), .DATA_WRITE(DATA_WRITE), .read_address(read_address),
    .Read_Enable(Read_Enable), .DATA_READ(data_o[1]), .Read_Valid(valid_o[1]),
    .Clear_Request(Clear_Request), .Busy(busy_o[1])
  );

  ram_dp_clear #(.DEPTH(200), .CLEAR_VALUE(16'hA5C3)) dut2 (
    .clock(clock), .reset(reset), .write_address(write_address), .Write_Enable(Write_Enable),
    .Byte_Enable(Byte_Enable), .DATA_WRITE(DATA_WRITE), .read_address(read_address),
    .Read_Enable(Read_Enable), .DATA_READ(data_o[2]), .Read_Valid(valid_o[2]),
    .Clear_Request(Clear_Request), .Busy(busy_o[2])
  );

  always #5 clock = ~clock;

  // Reference model: per-instance memory image, clear progress and a queue of pending reads
  int          m_depth [3];
  int          m_lat [3];
  int          m_rdw [3];
  logic [15:0] m_cv [3];
  logic [15:0] m_mem [3][256];
  bit          m_clearing [3];
  int          m_clr [3];
  int unsigned m_due [3][$];
  logic [15:0] m_qd [3][$];
  bit          m_valid [3];
  logic [15:0] m_data [3];
  int unsigned cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic [15:0] before_w, after_w;
    int ra, wa;
    cyc++;
    ra = int'(read_address);
    wa = int'(write_address);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_clearing[i] = 1'b1;
        m_clr[i]      = 0;
        m_due[i].delete();
        m_qd[i].delete();
        m_valid[i]    = 1'b0;
        m_data[i]     = 16'h0000;
      end else begin
        if (m_clearing[i]) begin
          m_mem[i][m_clr[i]] = m_cv[i];
          m_clr[i]++;
          if (m_clr[i] == m_depth[i]) m_clearing[i] = 1'b0;
        end else begin
          before_w = (ra < m_depth[i]) ? m_mem[i][ra] : m_cv[i];
          if (Write_Enable && wa < m_depth[i]) begin
            for (int b = 0; b < 2; b++) begin
              if (Byte_Enable[b]) m_mem[i][wa][b*8 +: 8] = DATA_WRITE[b*8 +: 8];
            end
          end
          after_w = (ra < m_depth[i]) ? m_mem[i][ra] : m_cv[i];
          if (Read_Enable) begin
            m_due[i].push_back(cyc + int'(m_lat[i]) - 1);
            m_qd[i].push_back((m_rdw[i] == 1) ? after_w : before_w);
          end
          if (Clear_Request) begin
            m_clearing[i] = 1'b1;
            m_clr[i]      = 0;
          end
        end
        m_valid[i] = 1'b0;
        if (m_due[i].size() > 0 && m_due[i][0] == cyc) begin
          m_valid[i] = 1'b1;
          m_data[i]  = m_qd[i].pop_front();
          void'(m_due[i].pop_front());
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_busy%0d", i), 32'(busy_o[i]), 32'(m_clearing[i]));
      chk($sformatf("model_valid%0d", i), 32'(valid_o[i]), 32'(m_valid[i]));
      chk($sformatf("model_data%0d", i), 32'(data_o[i]), 32'(m_data[i]));
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [7:0]  ra;
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int n, bad, vcnt, nz;
    checks = 0; errors = 0; cyc = 0;
    clock = 1'b0; reset = 1'b1;
    write_address = 8'h00; Write_Enable = 1'b0; Byte_Enable = 2'b00; DATA_WRITE = 16'h0000;
    read_address = 8'h00; Read_Enable = 1'b0; Clear_Request = 1'b0;
    m_depth[0] = 256; m_lat[0] = 1; m_rdw[0] = 0; m_cv[0] = 16'h0000;
    m_depth[1] = 256; m_lat[1] = 2; m_rdw[1] = 1; m_cv[1] = 16'h0000;
    m_depth[2] = 200; m_lat[2] = 1; m_rdw[2] = 0; m_cv[2] = 16'hA5C3;
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 256; a++) m_mem[i][a] = 16'h0000;
    end

    //             we    be     wa     wd        re    ra     v0    d0        v1    d1
    tbl[0]  = '{1'b1, 2'b11, 8'h10, 16'hBEEF, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 2'b01, 8'h10, 16'h1234, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[2]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h10, 1'b1, 16'hBE34, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'hBE34, 1'b1, 16'hBE34};
    tbl[4]  = '{1'b1, 2'b11, 8'h07, 16'h1111, 1'b0, 8'h00, 1'b0, 16'hBE34, 1'b0, 16'hBE34};
    tbl[5]  = '{1'b1, 2'b11, 8'h07, 16'h2222, 1'b1, 8'h07, 1'b1, 16'h1111, 1'b0, 16'hBE34};
    tbl[6]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h07, 1'b1, 16'h2222, 1'b1, 16'h2222};
    tbl[7]  = '{1'b1, 2'b00, 8'h08, 16'hABCD, 1'b1, 8'h08, 1'b1, 16'h0000, 1'b1, 16'h2222};
    tbl[8]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h08, 1'b1, 16'h0000, 1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 2'b11, 8'h01, 16'h000A, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[10] = '{1'b1, 2'b11, 8'h02, 16'h000B, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[11] = '{1'b1, 2'b11, 8'h03, 16'h000C, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 16'h0000};
    tbl[12] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h01, 1'b1, 16'h000A, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h02, 1'b1, 16'h000B, 1'b1, 16'h000A};
    tbl[14] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b1, 8'h03, 1'b1, 16'h000C, 1'b1, 16'h000B};
    tbl[15] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h000C, 1'b1, 16'h000C};
    tbl[16] = '{1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h000C, 1'b0, 16'h000C};

    // Reset state
    repeat (3) step();
    chk("reset_busy", 32'(busy_o[0]), 32'd1);
    chk("reset_valid", 32'(valid_o[0]), 32'd0);
    chk("reset_data", 32'(data_o[0]), 32'd0);

    // Power-up clear with a read held pending
    reset = 1'b0; Read_Enable = 1'b1; read_address = 8'h05;
    n = 0; bad = 0;
    while (busy_o[0] && n < 600) begin
      if (valid_o[0]) bad++;
      n++;
      step();
    end
    chk("powerup_busy_cycles", 32'(n), 32'd256);
    chk("powerup_no_valid", 32'(bad), 32'd0);
    step();
    chk("first_read_valid", 32'(valid_o[0]), 32'd1);
    chk("first_read_data", 32'(data_o[0]), 32'h0000);
    Read_Enable = 1'b0;
    repeat (2) step();

    // Directed vector table
    for (int k = 0; k < 17; k++) begin
      Write_Enable = tbl[k].we; Byte_Enable = tbl[k].be; write_address = tbl[k].wa;
      DATA_WRITE = tbl[k].wd; Read_Enable = tbl[k].re; read_address = tbl[k].ra;
      step();
      chk($sformatf("tbl%0d_v0", k), 32'(valid_o[0]), 32'(tbl[k].v0));
      chk($sformatf("tbl%0d_d0", k), 32'(data_o[0]), 32'(tbl[k].d0));
      chk($sformatf("tbl%0d_v1", k), 32'(valid_o[1]), 32'(tbl[k].v1));
      chk($sformatf("tbl%0d_d1", k), 32'(data_o[1]), 32'(tbl[k].d1));
    end

    // Randomized traffic with occasional clears and resets
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
      Clear_Request = ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0;
      Write_Enable  = 1'($urandom_range(0, 1));
      Read_Enable   = 1'($urandom_range(0, 1));
      Byte_Enable   = 2'($urandom_range(0, 3));
      DATA_WRITE    = 16'($urandom);
      write_address = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      read_address  = ($urandom_range(0, 3) == 0) ? write_address : 8'($urandom_range(0, 255));
      step();
    end
    reset = 1'b0; Clear_Request = 1'b0; Write_Enable = 1'b0; Read_Enable = 1'b0;
    n = 0;
    while (busy_o != 3'b000 && n < 600) begin
      n++;
      step();
    end
    chk("drain_busy", 32'(busy_o), 32'd0);

    // Fill, then clear with a read in the request cycle and a second request mid-clear
    for (int a = 0; a < 256; a++) begin
      Write_Enable = 1'b1; Byte_Enable = 2'b11; write_address = 8'(a);
      DATA_WRITE = 16'($urandom) | 16'h0001;
      step();
    end
    Write_Enable = 1'b0;
    Clear_Request = 1'b1; Read_Enable = 1'b1; read_address = 8'h10;
    step();
    chk("clr_rd_busy0", 32'(busy_o[0]), 32'd1);
    chk("clr_rd_valid0", 32'(valid_o[0]), 32'd1);
    chk("clr_rd_valid1_early", 32'(valid_o[1]), 32'd0);
    Clear_Request = 1'b0; Read_Enable = 1'b0;
    n = 0;
    while (busy_o[0] && n < 600) begin
      n++;
      Clear_Request = (n == 10) ? 1'b1 : 1'b0;
      step();
      if (n == 1) chk("clr_rd_valid1_late", 32'(valid_o[1]), 32'd1);
    end
    Clear_Request = 1'b0;
    chk("reclear_busy_cycles", 32'(n), 32'd256);
    vcnt = 0; nz = 0;
    for (int a = 0; a < 256; a++) begin
      Read_Enable = 1'b1; read_address = 8'(a);
      step();
      if (valid_o[0]) vcnt++;
      if (valid_o[0] && data_o[0] != 16'h0000) nz++;
    end
    Read_Enable = 1'b0;
    chk("sweep_valid_count", 32'(vcnt), 32'd256);
    chk("sweep_nonzero", 32'(nz), 32'd0);
    repeat (2) step();

    // Reset in the middle of a clear
    Write_Enable = 1'b1; Byte_Enable = 2'b11; write_address = 8'h09; DATA_WRITE = 16'h5A5A;
    step();
    Write_Enable = 1'b0; Read_Enable = 1'b1; read_address = 8'h09;
    step();
    Read_Enable = 1'b0;
    repeat (2) step();
    chk("pre_reset_data0", 32'(data_o[0]), 32'h5A5A);
    Clear_Request = 1'b1;
    step();
    Clear_Request = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midclr_reset_busy", 32'(busy_o[0]), 32'd1);
      chk("midclr_reset_valid", 32'(valid_o[0]), 32'd0);
      chk("midclr_reset_data0", 32'(data_o[0]), 32'd0);
      chk("midclr_reset_data1", 32'(data_o[1]), 32'd0);
    end
    reset = 1'b0;
    n = 0;
    while (busy_o[0] && n < 600) begin
      n++;
      step();
    end
    chk("restart_busy_cycles", 32'(n), 32'd256);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
